// File: rtl/tx_pkg.sv
// Constants and state encoding shared by the neighbor-update framer and deframer.
package tx_pkg;

   localparam int          TX_WORD_WIDTH = 16;
   localparam logic [15:0] TX_HDR_MARKER = 16'hA5C3;
   localparam int          FRAME_WORDS   = 7;

   // Word positions inside a frame: header, five record fields, checksum.
   localparam logic [2:0] IDX_HDR     = 3'd0;
   localparam logic [2:0] IDX_SRC     = 3'd1;
   localparam logic [2:0] IDX_BATT    = 3'd2;
   localparam logic [2:0] IDX_VALUE   = 3'd3;
   localparam logic [2:0] IDX_CLUSTER = 3'd4;
   localparam logic [2:0] IDX_DEST    = 3'd5;
   localparam logic [2:0] IDX_CHK     = 3'd6;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } tx_state_e;

endpackage

// File: rtl/neighbor_frame_tx_stall_timer.sv
// Counts consecutive stalled cycles and flags the cycle in which the limit is hit.
module stall_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clock,
   input  logic nrst,
   input  logic clr,
   input  logic stall,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LIMIT_M1 = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (stall && (count_q != LIMIT)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (nrst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // A stall in this cycle would bring the count to the limit; a handshake instead clears it.
   assign expired = (TIMEOUT_CYCLES != 0) && stall && (count_q == LIMIT_M1);

endmodule

// File: rtl/neighbor_frame_tx.sv
// Latches one local node record and streams it as a 7-word checksummed frame over valid/ready.
module neighbor_frame_tx
   import tx_pkg::*;
#(
   parameter int                    WORD_WIDTH     = TX_WORD_WIDTH,
   parameter logic [WORD_WIDTH-1:0] HDR_MARKER     = WORD_WIDTH'(TX_HDR_MARKER),
   parameter int                    TIMEOUT_CYCLES = 16
) (
   input  logic                  clock,
   input  logic                  nrst,
   input  logic                  en,
   input  logic [WORD_WIDTH-1:0] fsourceID,
   input  logic [WORD_WIDTH-1:0] fbatteryStat,
   input  logic [WORD_WIDTH-1:0] fValue,
   input  logic [WORD_WIDTH-1:0] fclusterID,
   input  logic [WORD_WIDTH-1:0] fdestinationID,
   input  logic                  tx_ready,
   output logic [WORD_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   output logic                  tx_last,
   output logic                  busy,
   output logic                  done_tx,
   output logic                  err_timeout
);

   tx_state_e             state_q,   state_d;
   logic [2:0]            idx_q,     idx_d;
   logic [WORD_WIDTH-1:0] src_q,     src_d;
   logic [WORD_WIDTH-1:0] batt_q,    batt_d;
   logic [WORD_WIDTH-1:0] value_q,   value_d;
   logic [WORD_WIDTH-1:0] cluster_q, cluster_d;
   logic [WORD_WIDTH-1:0] dest_q,    dest_d;
   logic [WORD_WIDTH-1:0] chk_q,     chk_d;
   logic                  done_q,    done_d;
   logic                  err_q,     err_d;

   logic                  frame_start;
   logic                  handshake;
   logic                  stall;
   logic                  expired;
   logic [WORD_WIDTH-1:0] word;

   assign tx_valid    = (state_q == ST_SEND);
   assign busy        = tx_valid;
   assign handshake   = tx_valid & tx_ready;
   assign stall       = tx_valid & ~tx_ready;
   assign frame_start = (state_q == ST_IDLE) & en;

   stall_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_stall_timer (
      .clock  (clock),
      .nrst   (nrst),
      .clr    (handshake | frame_start),
      .stall  (stall),
      .expired(expired)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      src_d     = src_q;
      batt_d    = batt_q;
      value_d   = value_q;
      cluster_d = cluster_q;
      dest_d    = dest_q;
      chk_d     = chk_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d   = ST_SEND;
               idx_d     = IDX_HDR;
               src_d     = fsourceID;
               batt_d    = fbatteryStat;
               value_d   = fValue;
               cluster_d = fclusterID;
               dest_d    = fdestinationID;
               chk_d     = HDR_MARKER ^ fsourceID ^ fbatteryStat ^ fValue
                           ^ fclusterID ^ fdestinationID;
            end
         end
         ST_SEND: begin
            // A handshake takes priority over an expiring stall in the same cycle.
            if (tx_ready) begin
               if (idx_q == IDX_CHK) begin
                  state_d = ST_IDLE;
                  idx_d   = IDX_HDR;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else if (expired) begin
               state_d = ST_IDLE;
               idx_d   = IDX_HDR;
               err_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (nrst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         src_q     <= '0;
         batt_q    <= '0;
         value_q   <= '0;
         cluster_q <= '0;
         dest_q    <= '0;
         chk_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         src_q     <= src_d;
         batt_q    <= batt_d;
         value_q   <= value_d;
         cluster_q <= cluster_d;
         dest_q    <= dest_d;
         chk_q     <= chk_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      word = '0;
      case (idx_q)
         IDX_HDR:     word = HDR_MARKER;
         IDX_SRC:     word = src_q;
         IDX_BATT:    word = batt_q;
         IDX_VALUE:   word = value_q;
         IDX_CLUSTER: word = cluster_q;
         IDX_DEST:    word = dest_q;
         IDX_CHK:     word = chk_q;
         default:     word = '0;
      endcase
   end

   // Data and last are forced low outside a frame so the idle bus reads as zero.
   assign tx_data     = tx_valid ? word : '0;
   assign tx_last     = tx_valid && (idx_q == IDX_CHK);
   assign done_tx     = done_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_neighbor_frame_tx.sv
// Directed self-checking bench for neighbor_frame_tx (timeout 16 instance and timeout-disabled instance).
module tb_neighbor_frame_tx;

   logic        clock = 1'b0;
   logic        nrst  = 1'b1;
   logic        en    = 1'b0;
   logic        en0   = 1'b0;
   logic [15:0] fsourceID      = '0;
   logic [15:0] fbatteryStat   = '0;
   logic [15:0] fValue         = '0;
   logic [15:0] fclusterID     = '0;
   logic [15:0] fdestinationID = '0;
   logic        txReady  = 1'b0;
   logic        txReady0 = 1'b0;

   logic [15:0] txData,  txData0;
   logic        txValid, txValid0;
   logic        txLast,  txLast0;
   logic        busy,    busy0;
   logic        doneTx,  doneTx0;
   logic        errTimeout, errTimeout0;

   int          checkCount = 0;
   int          failCount  = 0;
   logic [15:0] expWords [7];

   always #5 clock = ~clock;

   neighbor_frame_tx #(.TIMEOUT_CYCLES(16)) dut (
      .clock(clock), .nrst(nrst), .en(en),
      .fsourceID(fsourceID), .fbatteryStat(fbatteryStat), .fValue(fValue),
      .fclusterID(fclusterID), .fdestinationID(fdestinationID),
      .tx_ready(txReady), .tx_data(txData), .tx_valid(txValid), .tx_last(txLast),
      .busy(busy), .done_tx(doneTx), .err_timeout(errTimeout)
   );

   neighbor_frame_tx #(.TIMEOUT_CYCLES(0)) dut0 (
      .clock(clock), .nrst(nrst), .en(en0),
      .fsourceID(fsourceID), .fbatteryStat(fbatteryStat), .fValue(fValue),
      .fclusterID(fclusterID), .fdestinationID(fdestinationID),
      .tx_ready(txReady0), .tx_data(txData0), .tx_valid(txValid0), .tx_last(txLast0),
      .busy(busy0), .done_tx(doneTx0), .err_timeout(errTimeout0)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic driveFields(input logic [15:0] s, input logic [15:0] b, input logic [15:0] v,
                              input logic [15:0] c, input logic [15:0] d);
      fsourceID = s; fbatteryStat = b; fValue = v; fclusterID = c; fdestinationID = d;
   endtask

   // Reference frame: header, fields, XOR checksum.
   task automatic loadExpected(input logic [15:0] s, input logic [15:0] b, input logic [15:0] v,
                               input logic [15:0] c, input logic [15:0] d);
      expWords[0] = 16'hA5C3;
      expWords[1] = s;
      expWords[2] = b;
      expWords[3] = v;
      expWords[4] = c;
      expWords[5] = d;
      expWords[6] = 16'hA5C3 ^ s ^ b ^ v ^ c ^ d;
   endtask

   // Pulse en for one cycle with the given record; returns at the negedge where word 0 is shown.
   task automatic applyStimulus(input logic [15:0] s, input logic [15:0] b, input logic [15:0] v,
                                input logic [15:0] c, input logic [15:0] d);
      driveFields(s, b, v, c, d);
      en = 1'b1;
      @(negedge clock);
      en = 1'b0;
   endtask

   // mode 0: always ready; 1: 3 lows at word 2 then alternating; 2: 15 lows at word 3.
   task automatic collectFrame(input int mode, input bit chgFields, input bit dropEn);
      int   idx  = 0;
      int   cyc  = 0;
      int   lows = 0;
      bit   alt  = 1'b1;
      logic rdy;
      while (idx < 7 && cyc < 300) begin
         rdy = 1'b1;
         if (mode == 1 && idx >= 2) begin
            if (lows < 3) begin
               rdy = 1'b0;
               lows++;
            end else begin
               rdy = alt;
               alt = ~alt;
            end
         end else if (mode == 2 && idx == 3 && lows < 15) begin
            rdy = 1'b0;
            lows++;
         end
         if (chgFields && idx == 3) driveFields(16'h0022, 16'h7FFF, 16'h1234, 16'h0002, 16'h0009);
         if (dropEn && idx == 3) en = 1'b0;
         txReady = rdy;
         checkOutput("frame_valid", txValid, 1);
         checkOutput("frame_busy", busy, 1);
         checkOutput($sformatf("word%0d", idx), txData, expWords[idx]);
         checkOutput($sformatf("last%0d", idx), txLast, (idx == 6));
         checkOutput("no_err_in_frame", errTimeout, 0);
         checkOutput("no_done_in_frame", doneTx, 0);
         if (rdy) idx++;
         cyc++;
         @(negedge clock);
      end
      checkOutput("frame_complete", idx, 7);
      checkOutput("done_pulse", doneTx, 1);
      checkOutput("end_valid", txValid, 0);
      checkOutput("end_busy", busy, 0);
      checkOutput("end_err", errTimeout, 0);
      txReady = 1'b1;
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clock);
      checkOutput("rst_valid", txValid, 0);
      checkOutput("rst_data", txData, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", doneTx, 0);
      checkOutput("rst_err", errTimeout, 0);
      nrst = 1'b0;
      @(negedge clock);

      // Test 1: basic frame, literal expected words
      $display("[TB] basic frame");
      expWords[0] = 16'hA5C3; expWords[1] = 16'h000F; expWords[2] = 16'h5999;
      expWords[3] = 16'h0680; expWords[4] = 16'h0001; expWords[5] = 16'h0003;
      expWords[6] = 16'hFAD7;
      txReady = 1'b1;
      applyStimulus(16'h000F, 16'h5999, 16'h0680, 16'h0001, 16'h0003);
      collectFrame(0, 1'b0, 1'b0);
      @(negedge clock);
      checkOutput("done_one_cycle", doneTx, 0);

      // Test 2: backpressure
      $display("[TB] backpressure");
      applyStimulus(16'h000F, 16'h5999, 16'h0680, 16'h0001, 16'h0003);
      collectFrame(1, 1'b0, 1'b0);
      @(negedge clock);

      // Test 3a: timeout abort after 16 stalled cycles at word 3
      $display("[TB] timeout abort");
      loadExpected(16'h000F, 16'h5999, 16'h0680, 16'h0001, 16'h0003);
      applyStimulus(16'h000F, 16'h5999, 16'h0680, 16'h0001, 16'h0003);
      for (int i = 0; i < 3; i++) begin
         txReady = 1'b1;
         checkOutput($sformatf("to_word%0d", i), txData, expWords[i]);
         @(negedge clock);
      end
      txReady = 1'b0;
      for (int i = 0; i < 16; i++) begin
         checkOutput("to_stall_valid", txValid, 1);
         checkOutput("to_stall_data", txData, 16'h0680);
         checkOutput("to_stall_err", errTimeout, 0);
         @(negedge clock);
      end
      checkOutput("to_err_pulse", errTimeout, 1);
      checkOutput("to_valid_drop", txValid, 0);
      checkOutput("to_busy_drop", busy, 0);
      checkOutput("to_no_done", doneTx, 0);
      @(negedge clock);
      checkOutput("to_err_clear", errTimeout, 0);
      checkOutput("to_still_idle", txValid, 0);
      txReady = 1'b1;
      applyStimulus(16'h000F, 16'h5999, 16'h0680, 16'h0001, 16'h0003);
      collectFrame(0, 1'b0, 1'b0);

      // Test 3b: ready returns on the 16th cycle, frame completes
      $display("[TB] ready on limit cycle");
      applyStimulus(16'h000F, 16'h5999, 16'h0680, 16'h0001, 16'h0003);
      collectFrame(2, 1'b0, 1'b0);
      @(negedge clock);

      // Test 4: en held, fields changed mid-frame, back-to-back frames
      $display("[TB] en held high");
      loadExpected(16'h0101, 16'h4000, 16'hFF00, 16'h0005, 16'h0007);
      driveFields(16'h0101, 16'h4000, 16'hFF00, 16'h0005, 16'h0007);
      en = 1'b1;
      @(negedge clock);
      collectFrame(0, 1'b1, 1'b0);
      loadExpected(16'h0022, 16'h7FFF, 16'h1234, 16'h0002, 16'h0009);
      @(negedge clock);
      collectFrame(0, 1'b0, 1'b1);
      @(negedge clock);
      checkOutput("en_not_queued", busy, 0);

      // Test 5: reset mid-frame at word 4
      $display("[TB] reset mid-frame");
      loadExpected(16'h000F, 16'h5999, 16'h0680, 16'h0001, 16'h0003);
      applyStimulus(16'h000F, 16'h5999, 16'h0680, 16'h0001, 16'h0003);
      for (int i = 0; i < 4; i++) @(negedge clock);
      checkOutput("rm_word4", txData, 16'h0001);
      nrst = 1'b1;
      @(negedge clock);
      checkOutput("rm_valid", txValid, 0);
      checkOutput("rm_data", txData, 0);
      checkOutput("rm_last", txLast, 0);
      checkOutput("rm_busy", busy, 0);
      checkOutput("rm_done", doneTx, 0);
      checkOutput("rm_err", errTimeout, 0);
      nrst = 1'b0;
      @(negedge clock);
      checkOutput("rm_done_after", doneTx, 0);
      checkOutput("rm_err_after", errTimeout, 0);
      applyStimulus(16'h000F, 16'h5999, 16'h0680, 16'h0001, 16'h0003);
      collectFrame(0, 1'b0, 1'b0);

      // Test 6: timeout disabled, 100 stalled cycles
      $display("[TB] timeout disabled");
      loadExpected(16'h0033, 16'h2000, 16'h0F0F, 16'h0004, 16'h0011);
      driveFields(16'h0033, 16'h2000, 16'h0F0F, 16'h0004, 16'h0011);
      txReady0 = 1'b0;
      en0 = 1'b1;
      @(negedge clock);
      en0 = 1'b0;
      for (int i = 0; i < 100; i++) begin
         checkOutput("nt_valid", txValid0, 1);
         checkOutput("nt_hdr", txData0, 16'hA5C3);
         checkOutput("nt_err", errTimeout0, 0);
         @(negedge clock);
      end
      for (int i = 0; i < 7; i++) begin
         txReady0 = 1'b1;
         checkOutput($sformatf("nt_word%0d", i), txData0, expWords[i]);
         checkOutput($sformatf("nt_last%0d", i), txLast0, (i == 6));
         @(negedge clock);
      end
      checkOutput("nt_done", doneTx0, 1);
      checkOutput("nt_end_err", errTimeout0, 0);
      checkOutput("nt_end_valid", txValid0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/neighbor_frame_tx.md
Name: neighbor_frame_tx

Overview:
- Transmit-side counterpart of the neighbor-update receive path that feeds the reward computation.
- Latches one local node record on an `en` pulse: source ID, battery status, Q-value, cluster ID, destination ID.
- Serialises the record as a 7-word frame (header, 5 fields, checksum) onto a 16-bit valid/ready stream toward the radio/link layer.
- Signals completion, or abort on a stalled sink.

Parameters:
- WORD_WIDTH, 16, width of every field and stream word.
- HDR_MARKER, 16'hA5C3, start-of-frame word.
- TIMEOUT_CYCLES, 16, consecutive stalled cycles before abort; 0 disables the timeout.

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- nrst  in  1  reset. Synchronous, active-high; the name is kept for consistency with the codebase.
- en  in  1  frame request; sampled only in IDLE.
- fsourceID  in  WORD_WIDTH  local node ID.
- fbatteryStat  in  WORD_WIDTH  battery level, Q1.15.
- fValue  in  WORD_WIDTH  local Q-value.
- fclusterID  in  WORD_WIDTH  cluster ID.
- fdestinationID  in  WORD_WIDTH  next-hop ID.
- tx_ready  in  1  sink accepts the current word.
- tx_data  out  WORD_WIDTH  current frame word.
- tx_valid  out  1  tx_data valid.
- tx_last  out  1  high with the checksum word.
- busy  out  1  frame in progress.
- done_tx  out  1  one-cycle pulse: frame fully accepted.
- err_timeout  out  1  one-cycle pulse: frame aborted.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; field registers, word index and stall counter cleared.
  - nrst mid-frame aborts silently: no done_tx, no err_timeout.
- States: IDLE -> SEND -> IDLE. SEND carries a 3-bit word index 0..6.
- Start:
  - In IDLE with en=1, latch all five fields in that cycle.
  - Next cycle: SEND, index 0, tx_valid=1, busy=1.
  - Inputs may change after the latch cycle without affecting the frame.
- Word order by index:
  - 0 HDR_MARKER
  - 1 src
  - 2 batt
  - 3 value
  - 4 cluster
  - 5 dest
  - 6 CHK = XOR of HDR_MARKER and the five latched fields
- Checksum is computed in the latch cycle and registered.
- Handshake:
  - A word transfers in a cycle with tx_valid & tx_ready.
  - tx_data and tx_last stay stable while tx_valid & !tx_ready.
  - tx_valid never drops mid-frame except on timeout abort or reset.
- Throughput: with tx_ready held high, 7 words go out in 7 consecutive cycles.
- Completion:
  - On the index-6 handshake, next cycle: done_tx=1, busy=0, tx_valid=0, state IDLE.
  - en in that same cycle is accepted, so back-to-back frames have 1 idle cycle between them.
- en while busy is ignored, not queued.
- Stall counter:
  - Cleared on every handshake and on frame start.
  - Increments each cycle with tx_valid & !tx_ready.
- Timeout abort (TIMEOUT_CYCLES != 0):
  - When the counter reaches TIMEOUT_CYCLES, next cycle: tx_valid=0, busy=0, err_timeout=1, state IDLE.
  - A handshake in the cycle the limit is reached wins: that word transfers and the counter clears.
- The counter saturates at TIMEOUT_CYCLES; its width is clog2(TIMEOUT_CYCLES+1).
- done_tx and err_timeout are never asserted together.

Decomposition:
- Shared package (tx_pkg):
  - WORD_WIDTH default
  - HDR_MARKER
  - FRAME_WORDS = 7
  - word-index constants IDX_HDR..IDX_CHK
  - state encoding
- The same package is used by the receive-side deframer.
- One sub-module: stall_timer.
  - Ports: clock, nrst, clr, stall; outputs expired.
  - Parameter TIMEOUT_CYCLES.
- Framing FSM, field registers and checksum stay in neighbor_frame_tx.

Test Plan:
1. Basic frame:
   - Stimulus: src=000F, batt=5999, val=0680, clu=0001, dst=0003, en pulse, tx_ready=1.
   - Response: tx_data A5C3,000F,5999,0680,0001,0003,FAD7 on 7 consecutive cycles; tx_last only on FAD7; done_tx in the following cycle.
2. Backpressure:
   - Stimulus: same frame, tx_ready low for 3 cycles at index 2, then every other cycle.
   - Response: each word held stable while stalled; exact 7-word sequence; no err_timeout.
3. Timeout:
   - Stimulus: tx_ready low from index 3 for 16 cycles.
   - Response: err_timeout pulse, tx_valid falls, no done_tx. A following en produces a complete frame.
   - Also: tx_ready rising on cycle 16 completes the frame normally.
4. en handling:
   - Stimulus: en held high throughout; input fields changed mid-frame.
   - Response: first frame carries the latched values; second frame starts 1 cycle after done_tx with the new values.
5. Reset mid-frame:
   - Stimulus: nrst=1 at index 4.
   - Response: all outputs 0 the next cycle, no done_tx/err_timeout. A new en yields a full frame starting at A5C3.
6. TIMEOUT_CYCLES=0:
   - Stimulus: tx_ready low for 100 cycles, then high.
   - Response: no abort; frame completes with correct checksum.
